// File: rtl/cut_sequencer.sv
// cut_sequencer
// Job-level sequencer for the cutting machine. For each piece of a job it
// requests one feed step, waits a fixed idle gap, requests one cut step and
// (between pieces) waits the gap again. Every step is a request/end
// handshake guarded by a watchdog; abort_i cancels a job or clears an error.
//
// Ports
//   clk, rst_n      system clock, synchronous active-low reset
//   start_i         start a job (only honoured in IDLE)
//   abort_i         cancel the running job / clear a watchdog error
//   piece_count_i   pieces to produce, latched at start
//   feed_len_i      feed length per piece, latched at start
//   feed_o          feed request level, feed_len_o carries the length
//   feed_end_i      feed controller done pulse
//   cut_o           cut request level
//   cut_end_i       cut controller done pulse
//   piece_idx_o     pieces completed in the current job
//   busy_o          job in progress
//   done_o          one-cycle pulse when the job completes
//   error_o         watchdog fired, held until abort_i or reset
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | waiting for start_i
// S_FEED  | feed_o high, waiting for feed_end_i
// S_GAP_F | idle gap between a feed and its cut
// S_CUT   | cut_o high, waiting for cut_end_i
// S_GAP_C | idle gap between a cut and the next feed
// S_ERROR | a step timed out, waiting for abort_i

module cut_sequencer #(
    parameter int CNT_W      = 8,
    parameter int LEN_W      = 16,
    parameter int GAP_CYCLES = 10,
    parameter int TIMEOUT    = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] piece_count_i,
    input  logic [LEN_W-1:0] feed_len_i,
    output logic             feed_o,
    output logic [LEN_W-1:0] feed_len_o,
    input  logic             feed_end_i,
    output logic             cut_o,
    input  logic             cut_end_i,
    output logic [CNT_W-1:0] piece_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);

    // Gap counter is loaded with GAP_CYCLES-1 and runs down to zero.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    // Watchdog counts completed cycles of a step; the step expires on the
    // edge that closes its TIMEOUT-th cycle.
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_GAP_F,
        S_CUT,
        S_GAP_C,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
    logic [CNT_W-1:0] idx_q, idx_d, idx_inc;
    logic [CNT_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             done_q, done_d;

    assign wd_inc  = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    assign idx_inc = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            wd_q    <= '0;
            idx_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            wd_q    <= wd_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        wd_d    = wd_q;
        idx_d   = idx_q;
        count_d = count_q;
        len_d   = len_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (piece_count_i != '0) begin
                        count_d = piece_count_i;
                        len_d   = feed_len_i;
                        idx_d   = '0;
                        wd_d    = '0;
                        state_d = S_FEED;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FEED: begin
                // abort beats the end pulse, the end pulse beats expiry
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (feed_end_i) begin
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP_F;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_GAP_F: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (gap_q == '0) begin
                    wd_d    = '0;
                    state_d = S_CUT;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_CUT: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (cut_end_i) begin
                    idx_d = idx_inc;
                    if (idx_inc == count_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP_C;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_GAP_C: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (gap_q == '0) begin
                    wd_d    = '0;
                    state_d = S_FEED;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_ERROR: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign feed_o      = (state_q == S_FEED);
    assign cut_o       = (state_q == S_CUT);
    assign busy_o      = (state_q == S_FEED) || (state_q == S_GAP_F) ||
                         (state_q == S_CUT)  || (state_q == S_GAP_C);
    assign error_o     = (state_q == S_ERROR);
    assign done_o      = done_q;
    assign feed_len_o  = len_q;
    assign piece_idx_o = idx_q;

endmodule

// File: doc/cut_sequencer.md
Name: cut_sequencer

Overview:
Job-level sequencer for the cutting machine. It drives the feed controller and the cut controller alternately: feed one piece length, cut, and repeat for a programmed piece count. Each step uses a request/end handshake, with a minimum idle gap between steps, a per-step watchdog and an abort path. It sits between the main control unit and the feed/cut motor controllers.

Parameters:
CNT_W, 8, width of piece count and piece index
LEN_W, 16, width of feed length (motor steps)
GAP_CYCLES, 10, cycles with all requests low between consecutive steps (≥1)
TIMEOUT, 1000000, max cycles a step may wait for its end pulse

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start_i  in  1  start job (sampled in IDLE only)
abort_i  in  1  abort job / clear error
piece_count_i  in  CNT_W  pieces to produce (latched at start)
feed_len_i  in  LEN_W  feed length per piece (latched at start)
feed_o  out  1  feed request, level
feed_len_o  out  LEN_W  latched feed length, valid while feed_o=1
feed_end_i  in  1  feed complete, 1-cycle pulse
cut_o  out  1  cut request, level, to cut controller cut_i
cut_end_i  in  1  cut complete, 1-cycle pulse, from cut controller cut_end_o
piece_idx_o  out  CNT_W  pieces completed in current job
busy_o  out  1  job in progress
done_o  out  1  job finished, 1-cycle pulse
error_o  out  1  watchdog fired, sticky

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n. All regs update on posedge clk.
- Reset: state IDLE. All outputs 0, including feed_len_o and piece_idx_o.
- States: IDLE, FEED, GAP_F, CUT, GAP_C, ERROR.
- IDLE: busy_o=0.
  - start_i=1 and piece_count_i≠0: latch count and length, clear piece_idx_o, go to FEED. feed_o and busy_o are 1 in the cycle after start is sampled.
  - start_i=1 and piece_count_i=0: done_o pulses the next cycle; stay in IDLE.
- FEED: feed_o=1. On feed_end_i: feed_o=0 next cycle, enter GAP_F.
- GAP_F: all requests low for exactly GAP_CYCLES cycles, then CUT.
- CUT: cut_o=1. On cut_end_i: cut_o=0 next cycle, and piece_idx_o increments in the same edge.
  - If the new piece_idx_o equals the latched count: done_o=1 for that cycle, busy_o=0, go to IDLE.
  - Otherwise enter GAP_C.
- GAP_C: GAP_CYCLES cycles with all requests low, then FEED.
- Latency (start to done, ideal handshakes): 1 + N·(t_feed + 1 + GAP + t_cut + 1) + (N−1)·GAP cycles. Each step ends exactly one cycle after its end pulse.
- Watchdog:
  - Counter clears on entry to FEED/CUT.
  - If TIMEOUT cycles elapse with no end pulse: drop the request, go to ERROR, error_o=1, busy_o=0.
  - If the end pulse arrives in the same cycle as expiry, the end pulse wins.
- ERROR: all requests low. start_i is ignored. abort_i clears error_o and returns to IDLE.
- abort_i in any non-IDLE state: next cycle is IDLE with feed_o=cut_o=0 and busy_o=0. No done_o; piece_idx_o holds.
- abort_i priority: above end pulses and watchdog in the same cycle.
- Spurious pulses: feed_end_i outside FEED and cut_end_i outside CUT are ignored. start_i while busy is ignored.
- Inputs are not re-sampled mid-job; feed_len_o stays constant for the whole job.
- Width rules:
  - piece_idx_o never wraps; maximum count is 2^CNT_W−1.
  - Watchdog counter is sized by $clog2(TIMEOUT+1) and saturates.

Test Plan:
- Single piece. count=1, len=500; feed_end 20 cycles after feed_o rises, cut_end 30 cycles after cut_o rises → one feed, exactly 10 low cycles, one cut. done_o pulses once, piece_idx_o=1, busy_o falls with done_o.
- Four pieces. count=4, len=1000; feed_end after 5 cycles, cut_end after 10000 cycles (cut controller define_speed=1000) → 4 feed/cut pairs. cut_o low ≥10 cycles between cuts; piece_idx_o steps 1..4; a single done_o.
- Zero count. count=0 with start → done_o pulse the next cycle; feed_o and cut_o never assert; busy_o stays 0.
- Watchdog. TIMEOUT=100, cut_end_i never returns → cut_o drops and error_o=1 exactly 100 cycles after cut_o rose. start_i is then ignored; abort_i clears error_o and returns to IDLE.
- Abort mid-job. Abort during the 2nd FEED of count=3, in the same cycle as feed_end_i → next cycle feed_o=0, busy_o=0, piece_idx_o=1, no done_o. A new start works normally.
- Spurious/reset.
  - cut_end_i pulses during FEED and GAP are ignored; counts are unaffected.
  - rst_n=0 during CUT → next edge all outputs 0, state IDLE.
